// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular exponentiation sequencer.
package rsa_pkg;
   localparam int RSA_WIDTH = 8;
   localparam int ONE       = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TOM_M = 3'd1,
      TOM_1 = 3'd2,
      SQR   = 3'd3,
      MUL   = 3'd4,
      FROM  = 3'd5,
      DONE  = 3'd6
   } rsa_state_e;

   typedef enum logic [1:0] {
      PH_ISSUE = 2'd0,
      PH_WAIT  = 2'd1,
      PH_ADV   = 2'd2
   } rsa_phase_e;
endpackage

// File: rtl/rsa_lead_one.sv
// Combinational highest-set-bit detector; used only when RSA_SKIP_LEADING_ZEROS_EN is defined.
module rsa_lead_one
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_e,
   output logic [CNT_W-1:0] o_idx,
   output logic             o_zero
);
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_e[i]) o_idx = CNT_W'(i);
      end
   end

   assign o_zero = (i_e == '0);
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external Montgomery multiplier.
// Optional macro RSA_SKIP_LEADING_ZEROS_EN starts the exponent scan at the top set bit of E.
//
// state | meaning
// IDLE  | waiting for start; eoc holds the last completion
// TOM_M | mont(M, Const) -> Mb, message into Montgomery domain
// TOM_1 | mont(1, Const) -> A, accumulator = R mod P
// SQR   | mont(A, A) -> A
// MUL   | mont(A, Mb) -> A, only when E[idx] = 1
// FROM  | mont(A, 1) -> C, back to normal domain
// DONE  | one cycle; eoc set, busy cleared
module rsa_modexp_ctrl
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             start,
   input  logic [WIDTH-1:0] P,
   input  logic [WIDTH-1:0] E,
   input  logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] Const,
   output logic             busy,
   output logic             eoc,
   output logic [WIDTH-1:0] C,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic             mul_done,
   input  logic [WIDTH-1:0] mul_res
);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

   rsa_state_e       r_state, w_state_nxt;
   rsa_phase_e       r_phase, w_phase_nxt;
   logic [CNT_W-1:0] r_idx, w_idx_nxt, w_idx_init;
   logic [WIDTH-1:0] r_e, r_m, r_const, r_mb, r_a, r_c;
   logic             r_busy, r_eoc, r_skip;
   logic             w_accept, w_capture, w_finish, w_e_zero;
   logic             w_unused_p;

   // The modulus goes straight to the multiplier datapath, not through here.
   assign w_unused_p = ^P;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
   rsa_lead_one #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lead_one (
      .i_e   (E),
      .o_idx (w_idx_init),
      .o_zero(w_e_zero)
   );
`else
   assign w_idx_init = CNT_W'(WIDTH-1);
   assign w_e_zero   = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_idx_nxt   = r_idx;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_finish    = 1'b0;
      mul_start   = 1'b0;
      mul_a       = '0;
      mul_b       = '0;
      case (r_state)
         IDLE: begin
            if (start && en) begin
               w_accept    = 1'b1;
               w_state_nxt = TOM_M;
               w_phase_nxt = PH_ISSUE;
               w_idx_nxt   = w_idx_init;
            end
         end
         DONE: begin
            if (en) w_state_nxt = IDLE;
         end
         default: begin
            case (r_state)
               TOM_M:   begin mul_a = r_m;   mul_b = r_const; end
               TOM_1:   begin mul_a = ONE_W; mul_b = r_const; end
               SQR:     begin mul_a = r_a;   mul_b = r_a;     end
               MUL:     begin mul_a = r_a;   mul_b = r_mb;    end
               FROM:    begin mul_a = r_a;   mul_b = ONE_W;   end
               default: ;
            endcase
            case (r_phase)
               PH_ISSUE: begin
                  if (en) begin
                     mul_start   = 1'b1;
                     w_phase_nxt = PH_WAIT;
                  end
               end
               // The multiplier is never gated, so its completion is taken even while en=0.
               PH_WAIT: begin
                  if (mul_done) begin
                     w_capture   = 1'b1;
                     w_phase_nxt = PH_ADV;
                  end
               end
               PH_ADV: begin
                  if (en) begin
                     w_phase_nxt = PH_ISSUE;
                     case (r_state)
                        TOM_M: w_state_nxt = TOM_1;
                        TOM_1: w_state_nxt = r_skip ? FROM : SQR;
                        SQR, MUL: begin
                           if (r_state == SQR && r_e[r_idx]) begin
                              w_state_nxt = MUL;
                           end else if (r_idx == '0) begin
                              w_state_nxt = FROM;
                           end else begin
                              w_idx_nxt   = r_idx - CNT_W'(1);
                              w_state_nxt = SQR;
                           end
                        end
                        FROM: begin
                           w_state_nxt = DONE;
                           w_finish    = 1'b1;
                        end
                        default: w_state_nxt = IDLE;
                     endcase
                  end
               end
               default: w_phase_nxt = PH_ISSUE;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_phase <= PH_ISSUE;
         r_idx   <= '0;
         r_e     <= '0;
         r_m     <= '0;
         r_const <= '0;
         r_mb    <= '0;
         r_a     <= '0;
         r_c     <= '0;
         r_busy  <= 1'b0;
         r_eoc   <= 1'b0;
         r_skip  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_idx   <= w_idx_nxt;
         if (w_accept) begin
            r_e     <= E;
            r_m     <= M;
            r_const <= Const;
            r_skip  <= w_e_zero;
            r_busy  <= 1'b1;
            r_eoc   <= 1'b0;
         end
         if (w_capture) begin
            case (r_state)
               TOM_M:   r_mb <= mul_res;
               FROM:    r_c  <= mul_res;
               default: r_a  <= mul_res;
            endcase
         end
         if (w_finish) begin
            r_busy <= 1'b0;
            r_eoc  <= 1'b1;
         end
      end
   end

   assign busy = r_busy;
   assign eoc  = r_eoc;
   assign C    = r_c;
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench: behavioural 3-cycle Montgomery multiplier plus plain-arithmetic modexp reference.
module tb_rsa_modexp_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n, en, start;
   logic [W-1:0] P, E, M, Const;
   logic         busy, eoc, mul_start, mul_done;
   logic [W-1:0] C, mul_a, mul_b, mul_res;

   int checks = 0;
   int errors = 0;
   int nstart = 0;

   logic [W-1:0] pa, pb;
   bit           pend = 1'b0;
   int           lat  = 0;

   always #5 clk = ~clk;

   rsa_modexp_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start),
      .P(P), .E(E), .M(M), .Const(Const),
      .busy(busy), .eoc(eoc), .C(C),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_res(mul_res)
   );

   function automatic int mont_ref(int a, int b, int p);
      int rinv = 0;
      for (int x = 1; x < p; x++) if (((x << W) % p) == 1) rinv = x;
      return ((a * b) % p) * rinv % p;
   endfunction

   function automatic int modexp_ref(int m, int e, int p);
      int r = 1 % p;
      for (int i = 0; i < e; i++) r = (r * m) % p;
      return r;
   endfunction

   function automatic int exp_ops(int e);
`ifdef RSA_SKIP_LEADING_ZEROS_EN
      int msb = -1;
      for (int i = 0; i < W; i++) if (e[i]) msb = i;
      return (e == 0) ? 3 : 3 + (msb + 1) + $countones(e);
`else
      return 2 + W + $countones(e) + 1;
`endif
   endfunction

   // Multiplier model: operands must hold and no new request may appear while a result is pending.
   always @(negedge clk) begin
      mul_done = 1'b0;
      if (!rst_n) begin
         pend = 1'b0;
      end else if (pend) begin
         checks++;
         assert (mul_start === 1'b0 && mul_a === pa && mul_b === pb) else begin
            errors++;
            $error("FAIL wait_stable: start=%b a=%0d b=%0d expected start=0 a=%0d b=%0d",
                   mul_start, mul_a, mul_b, pa, pb);
         end
         if (lat == 1) begin
            mul_done = 1'b1;
            mul_res  = W'(mont_ref(int'(pa), int'(pb), int'(P)));
            pend     = 1'b0;
         end else begin
            lat--;
         end
      end else if (mul_start === 1'b1) begin
         pa = mul_a;
         pb = mul_b;
         pend = 1'b1;
         lat  = 3;
         nstart++;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic launch(int p, int m, int e);
      @(posedge clk); #1;
      P = W'(p); M = W'(m); E = W'(e);
      Const = W'((1 << (2 * W)) % p);
      nstart = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
   endtask

   task automatic finish(string tag, int p, int m, int e);
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (eoc === 1'b1) begin ok = 1'b1; break; end
      end
      chk({tag, "_eoc_timeout"}, 32'(ok), 1);
      chk({tag, "_C"}, 32'(C), 32'(modexp_ref(m, e, p)));
      chk({tag, "_ops"}, 32'(nstart), 32'(exp_ops(e)));
      chk({tag, "_busy_end"}, 32'(busy), 0);
   endtask

   initial begin
      int p, m, e, n0;
      bit hit;
      rst_n = 1'b0; en = 1'b1; start = 1'b0;
      P = '0; E = '0; M = '0; Const = '0;
      mul_done = 1'b0; mul_res = '0;
      #12;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_eoc", 32'(eoc), 0);
      chk("rst_C", 32'(C), 0);
      chk("rst_mul_start", 32'(mul_start), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_mul_b", 32'(mul_b), 0);
      @(posedge clk); #1; rst_n = 1'b1;

      launch(13, 4, 5);   finish("basic", 13, 4, 5);
      chk("basic_C_const", 32'(C), 10);
      launch(13, 7, 0);   finish("e_zero", 13, 7, 0);
      launch(251, 2, 255); finish("full_exp", 251, 2, 255);
      chk("full_exp_C_const", 32'(C), 32);
      launch(13, 0, 9);   finish("m_zero", 13, 0, 9);

      // A second start while busy must not restart or recapture.
      launch(13, 4, 5);
      repeat (10) @(posedge clk); #1;
      M = 8'd9; E = 8'd7; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      finish("restart_ignored", 13, 4, 5);

      // Stall with en low mid-run.
      launch(13, 4, 5);
      repeat (15) @(posedge clk); #1;
      en = 1'b0; n0 = nstart;
      repeat (20) @(posedge clk); #1;
      chk("stall_no_start", 32'(nstart), 32'(n0));
      chk("stall_busy", 32'(busy), 1);
      en = 1'b1;
      finish("stall", 13, 4, 5);

      // Reset once the first squaring has been issued.
      launch(13, 4, 5);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (nstart >= 3) begin hit = 1'b1; break; end
      end
      chk("reach_sqr", 32'(hit), 1);
      rst_n = 1'b0; #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_eoc", 32'(eoc), 0);
      chk("midrst_C", 32'(C), 0);
      @(posedge clk); #1; rst_n = 1'b1;
      launch(13, 7, 11);  finish("after_rst", 13, 7, 11);

      // Back-to-back: start accepted one cycle after eoc.
      launch(13, 5, 3);
      chk("b2b_eoc_cleared", 32'(eoc), 0);
      finish("b2b", 13, 5, 3);
      chk("b2b_C_const", 32'(C), 8);

      for (int k = 0; k < 6; k++) begin
         p = 2 * $urandom_range(1, 127) + 1;
         m = $urandom_range(0, p - 1);
         e = $urandom_range(0, 255);
         launch(p, m, e);
         finish("random", p, m, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
